// File: rtl/timing_mon_pkg.sv
// timing_mon_pkg: FSM state type, err_flags bit positions and default widths
// shared by the timing monitor and its pulse measurement sub-block.
package timing_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam int ERR_PERIOD = 0;
    localparam int ERR_WIDTH  = 1;
    localparam int ERR_GSTART = 2;
    localparam int ERR_GLEN   = 3;
    localparam int ERR_CHIRP  = 4;
    localparam int ERR_SEQ    = 5;
    localparam int ERR_W      = 6;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_FRAME_W = 32;

endpackage

// File: rtl/timing_pulse_meas.sv
// timing_pulse_meas: edge detect plus saturating high-time and rise-to-rise
// counters for one timing-bus signal.
module timing_pulse_meas
    import timing_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    output logic             o_rise,
    output logic             o_fall,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic [CNT_W-1:0] o_rise_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sig_q;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_intv;

    assign o_rise     = i_sig & ~r_sig_q;
    assign o_fall     = ~i_sig & r_sig_q;
    assign o_high_cnt = r_high;
    assign o_rise_cnt = r_intv;

    // Both counters read N on the cycle the measured event is seen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sig_q <= 1'b0;
            r_high  <= '0;
            r_intv  <= '0;
        end else begin
            r_sig_q <= i_sig;
            if (o_rise) begin
                r_high <= CNT_ONE;
            end else if (i_sig && r_high != CNT_MAX) begin
                r_high <= r_high + CNT_ONE;
            end
            if (o_rise) begin
                r_intv <= CNT_ONE;
            end else if (r_intv != CNT_MAX) begin
                r_intv <= r_intv + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/timing_monitor.sv
// timing_monitor: passive per-CPI checker of the radar timing bus.
// Define TIMING_MON_CHK_EN to build the expected-value comparators.
module timing_monitor
    import timing_mon_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int FRAME_W = DEF_FRAME_W
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               PRI,
    input  logic               CPIB,
    input  logic               CPIE,
    input  logic               sample_gate,
    input  logic [15:0]        PRI_PERIOD,
    input  logic [7:0]         PRI_NUM,
    input  logic [7:0]         PRI_PULSE_WIDTH,
    input  logic [15:0]        START_SAMPLE,
    input  logic [15:0]        SAMPLE_LENGTH,
    input  logic               err_clr,
    output logic               meas_valid,
    output logic [CNT_W-1:0]   meas_period,
    output logic [CNT_W-1:0]   meas_width,
    output logic [CNT_W-1:0]   meas_gate_start,
    output logic [CNT_W-1:0]   meas_gate_len,
    output logic [7:0]         meas_chirps,
    output logic [FRAME_W-1:0] cpi_cnt,
    output logic [5:0]         err_flags
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t r_state;
    state_t w_state_nxt;

    logic r_cpib_q;
    logic r_cpie_q;
    logic w_cpib_rise;
    logic w_cpie_rise;

    logic             w_pri_rise;
    logic             w_pri_fall;
    logic             w_gate_rise;
    logic             w_gate_fall;
    logic [CNT_W-1:0] w_pri_high;
    logic [CNT_W-1:0] w_pri_intv;
    logic [CNT_W-1:0] w_gate_high;
    logic [CNT_W-1:0] w_unused_gate_intv;
    logic [CNT_W-1:0] r_gate_ofs;

    logic w_idle;
    logic w_active;
    logic w_report;
    logic w_load;
    logic w_seq_err;
    logic w_chirp_evt;

    logic [7:0]       r_cfg_num;
    logic [7:0]       r_chirps;
    logic             r_seen;
    logic [ERR_W-1:0] r_acc;
    logic [ERR_W-1:0] w_err_evt;
    logic [ERR_W-1:0] r_err_flags;
    logic [ERR_W-1:0] w_flags_nxt;

    logic [CNT_W-1:0] r_last_period;
    logic [CNT_W-1:0] r_last_width;
    logic [CNT_W-1:0] r_last_gstart;
    logic [CNT_W-1:0] r_last_glen;

    logic               r_meas_valid;
    logic [CNT_W-1:0]   r_meas_period;
    logic [CNT_W-1:0]   r_meas_width;
    logic [CNT_W-1:0]   r_meas_gstart;
    logic [CNT_W-1:0]   r_meas_glen;
    logic [7:0]         r_meas_chirps;
    logic [FRAME_W-1:0] r_cpi_cnt;

    timing_pulse_meas #(.CNT_W(CNT_W)) u_pri (
        .i_clk      (sys_clk),
        .i_rst      (rst),
        .i_sig      (PRI),
        .o_rise     (w_pri_rise),
        .o_fall     (w_pri_fall),
        .o_high_cnt (w_pri_high),
        .o_rise_cnt (w_pri_intv)
    );

    timing_pulse_meas #(.CNT_W(CNT_W)) u_gate (
        .i_clk      (sys_clk),
        .i_rst      (rst),
        .i_sig      (sample_gate),
        .o_rise     (w_gate_rise),
        .o_fall     (w_gate_fall),
        .o_high_cnt (w_gate_high),
        .o_rise_cnt (w_unused_gate_intv)
    );

    assign w_cpib_rise = CPIB & ~r_cpib_q;
    assign w_cpie_rise = CPIE & ~r_cpie_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_cpib_q   <= 1'b0;
            r_cpie_q   <= 1'b0;
            r_gate_ofs <= '0;
        end else begin
            r_cpib_q <= CPIB;
            r_cpie_q <= CPIE;
            if (w_pri_rise) begin
                r_gate_ofs <= CNT_ONE;
            end else if (r_gate_ofs != CNT_MAX) begin
                r_gate_ofs <= r_gate_ofs + CNT_ONE;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cpib_rise) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!w_cpib_rise && w_cpie_rise) w_state_nxt = ST_REPORT;
            end
            ST_REPORT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idle   = 1'b0;
        w_active = 1'b0;
        w_report = 1'b0;
        unique case (r_state)
            ST_IDLE:   w_idle   = 1'b1;
            ST_ACTIVE: w_active = 1'b1;
            ST_REPORT: w_report = 1'b1;
            default:   w_idle   = 1'b1;
        endcase
    end

    // A CPIB rise while active abandons the CPI and reloads in place.
    assign w_load      = w_cpib_rise & (w_idle | w_active);
    assign w_seq_err   = (w_active & w_cpib_rise)
                       | (w_idle & w_cpie_rise & ~w_cpib_rise);
    assign w_chirp_evt = w_active & w_pri_rise & ~w_cpie_rise & ~w_cpib_rise;

`ifdef TIMING_MON_CHK_EN
    logic [15:0] r_cfg_period;
    logic [7:0]  r_cfg_width;
    logic [15:0] r_cfg_start;
    logic [15:0] r_cfg_len;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_cfg_period <= '0;
            r_cfg_width  <= '0;
            r_cfg_start  <= '0;
            r_cfg_len    <= '0;
        end else if (w_load) begin
            r_cfg_period <= PRI_PERIOD;
            r_cfg_width  <= PRI_PULSE_WIDTH;
            r_cfg_start  <= START_SAMPLE;
            r_cfg_len    <= SAMPLE_LENGTH;
        end
    end

    always_comb begin
        w_err_evt = '0;
        w_err_evt[ERR_PERIOD] = w_chirp_evt & r_seen
                              & (w_pri_intv != CNT_W'(r_cfg_period));
        w_err_evt[ERR_WIDTH]  = w_active & r_seen & w_pri_fall
                              & (w_pri_high != CNT_W'(r_cfg_width));
        w_err_evt[ERR_GSTART] = w_active & r_seen & w_gate_rise
                              & (r_gate_ofs != CNT_W'(r_cfg_start));
        w_err_evt[ERR_GLEN]   = w_active
                              & ((r_seen & w_gate_fall
                                  & (w_gate_high != CNT_W'(r_cfg_len)))
                                 | (w_cpie_rise & sample_gate));
        w_err_evt[ERR_CHIRP]  = w_active & w_cpie_rise
                              & (r_chirps != r_cfg_num);
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{PRI_PERIOD, PRI_PULSE_WIDTH,
                            START_SAMPLE, SAMPLE_LENGTH};

    always_comb begin
        w_err_evt = '0;
        w_err_evt[ERR_CHIRP] = w_active & w_cpie_rise
                             & (r_chirps != r_cfg_num);
    end
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_cfg_num     <= '0;
            r_chirps      <= '0;
            r_seen        <= 1'b0;
            r_acc         <= '0;
            r_last_period <= '0;
            r_last_width  <= '0;
            r_last_gstart <= '0;
            r_last_glen   <= '0;
        end else if (w_load) begin
            r_cfg_num     <= PRI_NUM;
            r_chirps      <= w_pri_rise ? 8'd1 : 8'd0;
            r_seen        <= w_pri_rise;
            r_acc         <= '0;
            r_last_period <= '0;
            r_last_width  <= '0;
            r_last_gstart <= '0;
            r_last_glen   <= '0;
        end else if (w_active) begin
            if (w_chirp_evt) begin
                if (r_chirps != 8'hFF) r_chirps <= r_chirps + 8'd1;
                r_seen <= 1'b1;
                if (r_seen) r_last_period <= w_pri_intv;
            end
            if (r_seen && w_pri_fall)  r_last_width  <= w_pri_high;
            if (r_seen && w_gate_rise) r_last_gstart <= r_gate_ofs;
            if (r_seen && w_gate_fall) r_last_glen   <= w_gate_high;
            r_acc <= r_acc | w_err_evt;
        end
    end

    // Fresh accumulator and sequence bits win over a coincident clear.
    always_comb begin
        w_flags_nxt = err_clr ? '0 : r_err_flags;
        if (w_report) w_flags_nxt = w_flags_nxt | r_acc;
        if (w_seq_err) w_flags_nxt[ERR_SEQ] = 1'b1;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_meas_valid  <= 1'b0;
            r_meas_period <= '0;
            r_meas_width  <= '0;
            r_meas_gstart <= '0;
            r_meas_glen   <= '0;
            r_meas_chirps <= '0;
            r_cpi_cnt     <= '0;
            r_err_flags   <= '0;
        end else begin
            r_meas_valid <= w_report;
            r_err_flags  <= w_flags_nxt;
            if (w_report) begin
                r_meas_period <= r_last_period;
                r_meas_width  <= r_last_width;
                r_meas_gstart <= r_last_gstart;
                r_meas_glen   <= r_last_glen;
                r_meas_chirps <= r_chirps;
                r_cpi_cnt     <= r_cpi_cnt + FRAME_W'(1);
            end
        end
    end

    assign meas_valid      = r_meas_valid;
    assign meas_period     = r_meas_period;
    assign meas_width      = r_meas_width;
    assign meas_gate_start = r_meas_gstart;
    assign meas_gate_len   = r_meas_glen;
    assign meas_chirps     = r_meas_chirps;
    assign cpi_cnt         = r_cpi_cnt;
    assign err_flags       = r_err_flags;

endmodule

// File: tb/tb_timing_monitor.sv
// tb_timing_monitor: directed and randomized CPIs against a per-chirp model
// of the measurements and error flags the monitor should report.
module tb_timing_monitor;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        PRI;
    logic        CPIB;
    logic        CPIE;
    logic        sample_gate;
    logic [15:0] PRI_PERIOD;
    logic [7:0]  PRI_NUM;
    logic [7:0]  PRI_PULSE_WIDTH;
    logic [15:0] START_SAMPLE;
    logic [15:0] SAMPLE_LENGTH;
    logic        err_clr;
    logic        meas_valid;
    logic [15:0] meas_period;
    logic [15:0] meas_width;
    logic [15:0] meas_gate_start;
    logic [15:0] meas_gate_len;
    logic [7:0]  meas_chirps;
    logic [31:0] cpi_cnt;
    logic [5:0]  err_flags;

    int total = 0;
    int bad = 0;

    int cfg_per, cfg_w, cfg_s, cfg_l, cfg_num;
    int cp[$];
    int cw[$];
    int cs[$];
    int cl[$];
    logic [5:0] exp_flags;
    int exp_cpi;
    bit m_active;
    logic [5:0] chk_mask;

    timing_monitor #(.CNT_W(16), .FRAME_W(32)) dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .PRI             (PRI),
        .CPIB            (CPIB),
        .CPIE            (CPIE),
        .sample_gate     (sample_gate),
        .PRI_PERIOD      (PRI_PERIOD),
        .PRI_NUM         (PRI_NUM),
        .PRI_PULSE_WIDTH (PRI_PULSE_WIDTH),
        .START_SAMPLE    (START_SAMPLE),
        .SAMPLE_LENGTH   (SAMPLE_LENGTH),
        .err_clr         (err_clr),
        .meas_valid      (meas_valid),
        .meas_period     (meas_period),
        .meas_width      (meas_width),
        .meas_gate_start (meas_gate_start),
        .meas_gate_len   (meas_gate_len),
        .meas_chirps     (meas_chirps),
        .cpi_cnt         (cpi_cnt),
        .err_flags       (err_flags)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int per, input int w, input int s,
                           input int l, input int num);
        cfg_per = per; cfg_w = w; cfg_s = s; cfg_l = l; cfg_num = num;
        PRI_PERIOD      = 16'(per);
        PRI_PULSE_WIDTH = 8'(w);
        START_SAMPLE    = 16'(s);
        SAMPLE_LENGTH   = 16'(l);
        PRI_NUM         = 8'(num);
    endtask

    task automatic model_start();
        if (m_active) exp_flags[5] = 1'b1;
        m_active = 1'b1;
        cp.delete(); cw.delete(); cs.delete(); cl.delete();
    endtask

    task automatic cpib_pulse();
        model_start();
        CPIB = 1'b1;
        tick();
        CPIB = 1'b0;
        tick();
        tick();
    endtask

    task automatic chirp(input int p, input int w, input int s, input int l,
                         input bit cpib_first);
        if (cpib_first) model_start();
        cp.push_back(p); cw.push_back(w); cs.push_back(s); cl.push_back(l);
        for (int c = 0; c < p; c++) begin
            PRI         = (c < w);
            sample_gate = (c >= s) && (c < s + l);
            CPIB        = cpib_first && (c == 0);
            tick();
        end
        PRI = 1'b0;
        sample_gate = 1'b0;
        CPIB = 1'b0;
    endtask

    task automatic finish_cpi(input string nm);
        int n;
        logic [5:0] e;
        n = cp.size();
        e = '0;
        for (int k = 0; k < n - 1; k++) if (cp[k] != cfg_per) e[0] = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (cw[k] != cfg_w) e[1] = 1'b1;
            if (cs[k] != cfg_s) e[2] = 1'b1;
            if (cl[k] != cfg_l) e[3] = 1'b1;
        end
        if (n != cfg_num) e[4] = 1'b1;
        exp_flags = exp_flags | (e & chk_mask);
        exp_cpi++;
        m_active = 1'b0;
        CPIE = 1'b1;
        tick();
        chk({nm, "_mv_early"}, 64'(meas_valid), 64'd0);
        CPIE = 1'b0;
        tick();
        chk({nm, "_mv"}, 64'(meas_valid), 64'd1);
        chk({nm, "_chirps"}, 64'(meas_chirps), 64'(n > 255 ? 255 : n));
        chk({nm, "_period"}, 64'(meas_period), 64'(n > 1 ? cp[n-2] : 0));
        chk({nm, "_width"}, 64'(meas_width), 64'(cw[n-1]));
        chk({nm, "_gstart"}, 64'(meas_gate_start), 64'(cs[n-1]));
        chk({nm, "_glen"}, 64'(meas_gate_len), 64'(cl[n-1]));
        chk({nm, "_flags"}, 64'(err_flags), 64'(exp_flags));
        chk({nm, "_cpi"}, 64'(cpi_cnt), 64'(exp_cpi));
        tick();
        chk({nm, "_mv_drop"}, 64'(meas_valid), 64'd0);
    endtask

    task automatic run_cpi(input string nm, input int n, input int odd_idx,
                           input int odd_p, input int wid);
        cpib_pulse();
        for (int k = 0; k < n; k++)
            chirp(k == odd_idx ? odd_p : cfg_per, wid, cfg_s, cfg_l, 1'b0);
        finish_cpi(nm);
    endtask

    task automatic clear_errs(input string nm);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        exp_flags = '0;
        chk(nm, 64'(err_flags), 64'd0);
    endtask

    task automatic idle_cpie();
        CPIE = 1'b1;
        tick();
        CPIE = 1'b0;
        exp_flags[5] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_cpie_mv", 64'(meas_valid), 64'd0);
        end
        chk("idle_cpie_flags", 64'(err_flags), 64'(exp_flags));
        chk("idle_cpie_cpi", 64'(cpi_cnt), 64'(exp_cpi));
    endtask

    initial begin
        int n, p, w, s, l, hits;
        bit coinc;
`ifdef TIMING_MON_CHK_EN
        chk_mask = 6'h3F;
`else
        chk_mask = 6'h30;
`endif
        exp_flags = '0;
        exp_cpi = 0;
        m_active = 1'b0;
        rst = 1'b1;
        PRI = 1'b0; CPIB = 1'b0; CPIE = 1'b0; sample_gate = 1'b0;
        err_clr = 1'b0;
        set_cfg(100, 10, 20, 60, 32);
        repeat (3) tick();
        chk("rst_mv", 64'(meas_valid), 64'd0);
        chk("rst_period", 64'(meas_period), 64'd0);
        chk("rst_width", 64'(meas_width), 64'd0);
        chk("rst_chirps", 64'(meas_chirps), 64'd0);
        chk("rst_cpi", 64'(cpi_cnt), 64'd0);
        chk("rst_flags", 64'(err_flags), 64'd0);
        rst = 1'b0;
        tick();
        tick();

        run_cpi("nominal", 32, -1, 0, 10);
        run_cpi("stretch", 32, 6, 105, 10);
        run_cpi("short31", 31, -1, 0, 10);
        clear_errs("clr_after_short");

        idle_cpie();
        clear_errs("clr_after_idle");

        set_cfg(100, 10, 20, 60, 8);
        cpib_pulse();
        for (int k = 0; k < 5; k++)
            chirp(100, k == 2 ? 12 : 10, 20, 60, 1'b0);
        cpib_pulse();
        for (int k = 0; k < 8; k++) chirp(100, 10, 20, 60, 1'b0);
        finish_cpi("restart");
        clear_errs("clr_after_restart");

        set_cfg(100, 10, 20, 60, 32);
        run_cpi("width60", 32, -1, 0, 60);
        clear_errs("clr_after_width");

        for (int it = 0; it < 16; it++) begin
            set_cfg($urandom_range(30, 60), $urandom_range(2, 8),
                    $urandom_range(2, 10), $urandom_range(5, 15), 0);
            n = $urandom_range(3, 10);
            cfg_num = ($urandom_range(0, 3) == 0) ? n + 1 : n;
            PRI_NUM = 8'(cfg_num);
            coinc = 1'($urandom_range(0, 1));
            if (!coinc) cpib_pulse();
            for (int k = 0; k < n; k++) begin
                p = cfg_per; w = cfg_w; s = cfg_s; l = cfg_l;
                if ($urandom_range(0, 7) == 0) p += $urandom_range(0, 1) ? 1 : -1;
                if ($urandom_range(0, 7) == 0) w += $urandom_range(0, 1) ? 1 : -1;
                if ($urandom_range(0, 7) == 0) s += $urandom_range(0, 1) ? 1 : -1;
                if ($urandom_range(0, 7) == 0) l += $urandom_range(0, 1) ? 1 : -1;
                chirp(p, w, s, l, coinc && (k == 0));
            end
            finish_cpi($sformatf("rand%0d", it));
            if ($urandom_range(0, 2) == 0) clear_errs($sformatf("rand_clr%0d", it));
        end

        idle_cpie();
        set_cfg(50, 5, 5, 10, 4);
        cpib_pulse();
        chirp(50, 5, 5, 10, 1'b0);
        chirp(50, 5, 5, 10, 1'b0);
        PRI = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_flags", 64'(err_flags), 64'd0);
        chk("async_rst_cpi", 64'(cpi_cnt), 64'd0);
        chk("async_rst_period", 64'(meas_period), 64'd0);
        PRI = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_flags = '0;
        exp_cpi = 0;
        m_active = 1'b0;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (meas_valid !== 1'b0) hits++;
        end
        chk("async_rst_no_mv", 64'(hits), 64'd0);
        chk("async_rst_chirps", 64'(meas_chirps), 64'd0);

        set_cfg(40, 4, 6, 12, 5);
        run_cpi("post_rst", 5, -1, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
